// File: rtl/tilt_letter_entry.sv
// Tilt-and-button letter entry: turns held accelerometer tilts and two debounced
// buttons into three editable ASCII slots, a cursor and a word-complete flag.
module tilt_letter_entry #(
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] tilt_x,
    input  logic [2:0] tilt_y,
    input  logic       confirm,
    input  logic       clear,
    output logic [7:0] letter_sel_one,
    output logic [7:0] letter_sel_two,
    output logic [7:0] letter_sel_three,
    output logic [1:0] letter_index,
    output logic       word_done
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [7:0] LETTER_A = 8'h41;
    localparam logic [7:0] LETTER_Z = 8'h5A;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_FWD   = 3'd1,
        DIR_BACK  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    dir_e            dir_q, dir_d, dir_s;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fire_s;
    logic            conf_q, conf_prev_q, clr_q, clr_prev_q;
    logic            conf_rise_s, clr_rise_s;
    logic [7:0]      slot0_q, slot1_q, slot2_q;
    logic [7:0]      slot0_d, slot1_d, slot2_d;
    logic [7:0]      cur_slot_s, stepped_s;
    logic [1:0]      idx_q, idx_d;
    logic            done_q, done_d;

    function automatic logic [7:0] step_letter(input logic [7:0] c, input logic up);
        logic [7:0] r;
        if (up) begin
            r = (c == LETTER_Z) ? LETTER_A : c + 8'd1;
        end else begin
            r = (c == LETTER_A) ? LETTER_Z : c - 8'd1;
        end
        return r;
    endfunction

    assign conf_rise_s = conf_q & ~conf_prev_q;
    assign clr_rise_s  = clr_q & ~clr_prev_q;

    // Direction decode: Y axis wins over X axis.
    always_comb begin
        dir_s = DIR_NONE;
        if (tilt_y <= 3'd1) begin
            dir_s = DIR_BACK;
        end else if (tilt_y >= 3'd6) begin
            dir_s = DIR_FWD;
        end else if (tilt_x <= 3'd1) begin
            dir_s = DIR_LEFT;
        end else if (tilt_x >= 3'd6) begin
            dir_s = DIR_RIGHT;
        end else begin
            dir_s = DIR_NONE;
        end
    end

    // Hold FSM next state; fire_s marks the edge on which the count reaches HOLD_CYCLES.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        fire_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dir_s != DIR_NONE) begin
                    dir_d   = dir_s;
                    cnt_d   = CNT_ONE;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (dir_s == DIR_NONE) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else if (dir_s == dir_q) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                    if (cnt_q >= CNT_LAST) begin
                        fire_s  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    dir_d = dir_s;
                    cnt_d = CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (dir_s == DIR_NONE) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                dir_d   = DIR_NONE;
                state_d = ST_IDLE;
            end
        endcase
        if (clr_rise_s) begin
            cnt_d   = CNT_ZERO;
            dir_d   = DIR_NONE;
            state_d = ST_IDLE;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // Letter currently under the cursor and its stepped value.
    always_comb begin
        case (idx_q)
            2'd1:    cur_slot_s = slot1_q;
            2'd2:    cur_slot_s = slot2_q;
            default: cur_slot_s = slot0_q;
        endcase
        stepped_s = step_letter(cur_slot_s, dir_q == DIR_FWD);
    end

    // Slot/cursor/done update with priority clear > confirm > tilt action.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        slot2_d = slot2_q;
        idx_d   = idx_q;
        done_d  = done_q;
        if (clr_rise_s) begin
            slot0_d = LETTER_A;
            slot1_d = LETTER_A;
            slot2_d = LETTER_A;
            idx_d   = 2'd0;
            done_d  = 1'b0;
        end else if (conf_rise_s) begin
            if (!done_q) begin
                if (idx_q == 2'd2) begin
                    done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end else begin
                done_d = done_q;
            end
        end else if (fire_s && !done_q) begin
            case (dir_q)
                DIR_FWD, DIR_BACK: begin
                    case (idx_q)
                        2'd0:    slot0_d = stepped_s;
                        2'd1:    slot1_d = stepped_s;
                        2'd2:    slot2_d = stepped_s;
                        default: slot0_d = slot0_q;
                    endcase
                end
                DIR_RIGHT: begin
                    if (idx_q < 2'd2) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        idx_d = 2'd2;
                    end
                end
                DIR_LEFT: begin
                    if (idx_q > 2'd0) begin
                        idx_d = idx_q - 2'd1;
                    end else begin
                        idx_d = 2'd0;
                    end
                end
                default: idx_d = idx_q;
            endcase
        end else begin
            done_d = done_q;
        end
    end

    // State registers; button edge detectors keep sampling through a clear so a held level acts once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_NONE;
            cnt_q       <= CNT_ZERO;
            conf_q      <= 1'b0;
            conf_prev_q <= 1'b0;
            clr_q       <= 1'b0;
            clr_prev_q  <= 1'b0;
            slot0_q     <= LETTER_A;
            slot1_q     <= LETTER_A;
            slot2_q     <= LETTER_A;
            idx_q       <= 2'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            conf_q      <= confirm;
            conf_prev_q <= conf_q;
            clr_q       <= clear;
            clr_prev_q  <= clr_q;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            slot2_q     <= slot2_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
        end
    end

    assign letter_sel_one   = slot0_q;
    assign letter_sel_two   = slot1_q;
    assign letter_sel_three = slot2_q;
    assign letter_index     = idx_q;
    assign word_done        = done_q;

endmodule

// File: doc/tilt_letter_entry.md
# tilt_letter_entry

Upstream feeder for the three-slot letter display controller. Converts accelerometer tilt codes and two push-buttons into three editable 8-bit ASCII letter codes plus a cursor position. Its `letter_sel_one/two/three` outputs drive the controller's three letter-select inputs directly. A held forward or back tilt steps the letter in the current slot through A–Z. A held left or right tilt moves the cursor, a confirm press commits the slot, and a clear press restarts the word.

## Interface
- `HOLD_CYCLES`, default 25_000_000: consecutive cycles a tilt must be held before it acts (0.25 s at 100 MHz); minimum 2.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `tilt_x`  in  3  accelerometer X code, already synchronous to `clk`: ≤1 is left, ≥6 is right, otherwise neutral.
- `tilt_y`  in  3  accelerometer Y code, already synchronous to `clk`: ≤1 is back, ≥6 is forward, otherwise neutral.
- `confirm`  in  1  debounced button level; acts on its rising edge.
- `clear`  in  1  debounced button level; acts on its rising edge.
- `letter_sel_one`  out  8  ASCII code of slot 0.
- `letter_sel_two`  out  8  ASCII code of slot 1.
- `letter_sel_three`  out  8  ASCII code of slot 2.
- `letter_index`  out  2  cursor slot, 0..2; value 3 never occurs.
- `word_done`  out  1  high once slot 2 has been committed.

## Operation
- **Reset state** (`rst_n` low at a clock edge):
  - All three slots = 8'h41 ('A').
  - `letter_index` = 0, `word_done` = 0.
  - Hold FSM = IDLE, hold counter = 0, edge-detect registers = 0.
- **Direction decode**, each cycle:
  - `tilt_y` non-neutral gives FWD or BACK; Y has priority over X.
  - Otherwise `tilt_x` non-neutral gives LEFT or RIGHT.
  - Otherwise NONE.
- **Hold FSM**, states IDLE, HOLD, WAIT_NEUTRAL:
  - IDLE: on a non-NONE direction, latch it, counter = 1, go to HOLD.
  - HOLD, decoded direction equals the latched one: counter += 1. When counter reaches `HOLD_CYCLES`, fire one action and go to WAIT_NEUTRAL.
  - HOLD, decoded direction is NONE: counter = 0, go to IDLE.
  - HOLD, decoded direction is a different non-NONE value: latch the new direction, counter = 1, stay in HOLD.
  - WAIT_NEUTRAL: stay until the direction is NONE, then go to IDLE. There is no auto-repeat; each action needs a return to neutral.
  - Counter width is $clog2(HOLD_CYCLES+1) and saturates. It never wraps.
- **Actions**:
  - FWD: current slot increments; 'Z' (8'h5A) wraps to 'A'.
  - BACK: current slot decrements; 'A' wraps to 'Z'.
  - RIGHT: `letter_index` += 1, saturating at 2.
  - LEFT: `letter_index` -= 1, saturating at 0.
  - While `word_done` = 1, all tilt actions are suppressed. The FSM still runs and goes to WAIT_NEUTRAL as usual.
- **Confirm**, on a rising edge:
  - `word_done` = 0 and `letter_index` < 2: `letter_index` += 1.
  - `word_done` = 0 and `letter_index` = 2: `word_done` = 1.
  - `word_done` = 1: ignored.
- **Clear**, on a rising edge: the same state as reset, including FSM = IDLE and counter = 0.
- **Priority within one cycle**: `rst_n` > clear > confirm > tilt action.
  - If confirm and a tilt action coincide, only confirm takes effect, and the FSM still goes to WAIT_NEUTRAL.
- Slot contents are always within 8'h41..8'h5A.

## Timing
- All outputs are registered and hold their value between updates.
- Tilt action: the direction is first sampled at edge E0 and held through edge E0+`HOLD_CYCLES`−1. The output changes at edge E0+`HOLD_CYCLES`−1, counting the edge on which the counter reaches `HOLD_CYCLES`.
- Confirm or clear: the input is low at edge N−1 and high at edge N. Outputs update at edge N+1 (one register for edge detect, one for the update).
  - A level held high produces exactly one action.
- Reset mid-hold discards the partial count; no action fires.
- Reset is synchronous: asynchronous deassertion needs no special handling, and outputs are defined from the first edge with `rst_n` low.

## Test plan
(`HOLD_CYCLES` = 4 for simulation.)
- **Reset**: `rst_n` low for 2 cycles → slots = 8'h41 ×3, `letter_index` = 0, `word_done` = 0.
- **Step and wrap**: `tilt_y` = 7 held 4 cycles, then 3 → slot 0 = 8'h42 exactly once.
  - Hold 10 cycles → still one step.
  - From 'A', `tilt_y` = 0 held 4 cycles → 8'h5A.
- **Short and switching tilt**: `tilt_y` = 7 for 3 cycles, then 3 → no change.
  - `tilt_y` = 7 for 2 cycles, then `tilt_y` = 0 for 4 cycles → slot decrements once.
- **Cursor saturation**: `tilt_x` = 7 held 4 cycles, three times with neutral between → `letter_index` = 1, 2, 2.
  - `tilt_x` = 7 with `tilt_y` = 7 simultaneously → letter steps, cursor unchanged.
- **Word completion**: three confirm pulses → `letter_index` 0→1→2, then `word_done` = 1.
  - Further tilts and confirms → no output change.
  - Clear pulse → reset state one edge after detection.
- **Collision**: confirm edge and tilt completion on the same edge → only `letter_index` advances; slot unchanged; re-tilt requires neutral first.
